// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: first-word-fall-through read port, sticky overrun flag.
// Define RX_FIFO_TIMEOUT_EN to build the idle-timeout counter; otherwise o_timeout is tied low.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 4160
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            i_data,
    input  logic                  i_rcv,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overrun,
    input  logic                  i_clr_overrun,
    output logic                  o_timeout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_rx_fifo: illegal parameter value");
    end

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  full, empty, push, pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && i_ready;
    // When full, a same-cycle pop frees the slot the push overwrites.
    assign push  = i_rcv && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (i_rcv && full && !pop)
            overrun_d = 1'b1;
        else if (i_clr_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Read port depends only on registered pointer/count and memory state.
    assign o_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign o_valid   = !empty;
    assign o_count   = count_q;
    assign o_full    = full;
    assign o_empty   = empty;
    assign o_overrun = overrun_q;

`ifdef RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        tmo_d = tmo_q;
        if (push || pop || empty)
            tmo_d = '0;
        else if (tmo_q != TMO_MAX)
            tmo_d = tmo_q + 1'b1;
        // Fire only on the transition into saturation so it cannot re-fire.
        timeout_d = (tmo_d == TMO_MAX) && (tmo_q != TMO_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for basic push/pop, queue model for wrap/overrun/timeout.
module tb_uart_rx_fifo;
    localparam int DL  = 4;
    localparam int DEP = 16;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_rcv = 1'b0;
    logic       i_ready = 1'b0;
    logic       i_clr_overrun = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_full, o_empty, o_overrun, o_timeout;
    logic [DL:0] o_count;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] q[$];
    bit ovr_m;

    uart_rx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .i_data(i_data), .i_rcv(i_rcv),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rcv;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        logic       vld;
        logic [7:0] q;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       ovr;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rcv = 0; i_ready = 0; i_clr_overrun = 0; i_data = 0;
        rstn = 0;
        step();
        rstn = 1;
        q.delete();
        ovr_m = 0;
    endtask

    // One clock of stimulus, checked against the queue model.
    task automatic cyc(input logic rcv, input logic [7:0] d, input logic rdy, input logic clr);
        bit pop, push, full;
        i_rcv = rcv; i_data = d; i_ready = rdy; i_clr_overrun = clr;
        chk("valid", int'(o_valid), int'(q.size() != 0));
        full = (q.size() == DEP);
        pop  = (q.size() != 0) && rdy;
        if (pop) begin
            chk("pop data", int'(o_data), int'(q[0]));
            void'(q.pop_front());
        end
        push = rcv && (!full || pop);
        if (push) q.push_back(d);
        if (rcv && full && !pop) ovr_m = 1;
        else if (clr)            ovr_m = 0;
        step();
        i_rcv = 0; i_ready = 0; i_clr_overrun = 0;
        chk("count", int'(o_count), q.size());
        chk("overrun", int'(o_overrun), int'(ovr_m));
        chk("full", int'(o_full), int'(q.size() == DEP));
        chk("empty", int'(o_empty), int'(q.size() == 0));
        if (q.size() != 0) chk("head", int'(o_data), int'(q[0]));
        else               chk("head empty", int'(o_data), 0);
    endtask

    initial begin
        int hits, at;
        //          rcv data  rdy clr  vld q     cnt full empty ovr
        tv[0]  = '{1, 8'h11, 0, 0,   1, 8'h11, 1, 0, 0, 0};
        tv[1]  = '{1, 8'h22, 0, 0,   1, 8'h11, 2, 0, 0, 0};
        tv[2]  = '{1, 8'h33, 0, 0,   1, 8'h11, 3, 0, 0, 0};
        tv[3]  = '{0, 8'h00, 1, 0,   1, 8'h22, 2, 0, 0, 0};
        tv[4]  = '{0, 8'h00, 1, 0,   1, 8'h33, 1, 0, 0, 0};
        tv[5]  = '{0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 1, 0};
        tv[6]  = '{0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 1, 0};
        tv[7]  = '{1, 8'hAA, 1, 0,   1, 8'hAA, 1, 0, 0, 0};
        tv[8]  = '{1, 8'hBB, 1, 0,   1, 8'hBB, 1, 0, 0, 0};
        tv[9]  = '{0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 1, 0};
        tv[10] = '{0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 0};

        #2;
        chk("rst count", int'(o_count), 0);
        chk("rst valid", int'(o_valid), 0);
        chk("rst empty", int'(o_empty), 1);
        chk("rst full", int'(o_full), 0);
        chk("rst data", int'(o_data), 0);
        chk("rst overrun", int'(o_overrun), 0);
        chk("rst timeout", int'(o_timeout), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            i_rcv = tv[i].rcv; i_data = tv[i].data; i_ready = tv[i].rdy; i_clr_overrun = tv[i].clr;
            step();
            i_rcv = 0; i_ready = 0; i_clr_overrun = 0;
            chk($sformatf("tv%0d valid", i), int'(o_valid), int'(tv[i].vld));
            chk($sformatf("tv%0d data", i), int'(o_data), int'(tv[i].q));
            chk($sformatf("tv%0d count", i), int'(o_count), int'(tv[i].cnt));
            chk($sformatf("tv%0d full", i), int'(o_full), int'(tv[i].full));
            chk($sformatf("tv%0d empty", i), int'(o_empty), int'(tv[i].empty));
            chk($sformatf("tv%0d overrun", i), int'(o_overrun), int'(tv[i].ovr));
        end

        // Reset mid-operation
        do_reset();
        cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0);
        rstn = 0;
        #2;
        chk("midrst count", int'(o_count), 0);
        chk("midrst valid", int'(o_valid), 0);
        chk("midrst data", int'(o_data), 0);
        chk("midrst overrun", int'(o_overrun), 0);
        step();
        rstn = 1;
        q.delete(); ovr_m = 0;
        cyc(1, 8'hA5, 0, 0);
        chk("post-rst data", int'(o_data), 8'hA5);

        // Wrap: 40 bytes interleaved with pops, then drain
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1, 8'(i), (i % 3) != 0, 0);
        while (q.size() != 0) cyc(0, 8'h00, 1, 0);

        // Overrun, full+push+pop, set-vs-clear
        do_reset();
        for (int i = 0; i < DEP; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        chk("filled full", int'(o_full), 1);
        cyc(1, 8'hEE, 0, 0);
        chk("ovr set", int'(o_overrun), 1);
        chk("ovr count", int'(o_count), DEP);
        cyc(0, 8'h00, 0, 1);
        chk("ovr cleared", int'(o_overrun), 0);
        cyc(1, 8'h77, 1, 0);
        chk("full push+pop no ovr", int'(o_overrun), 0);
        chk("full push+pop count", int'(o_count), DEP);
        cyc(1, 8'h88, 0, 1);
        chk("set beats clear", int'(o_overrun), 1);
        while (q.size() != 0) cyc(0, 8'h00, 1, 0);
        chk("drained empty", int'(o_empty), 1);

        // Timeout: single push, idle
        do_reset();
        cyc(1, 8'h5A, 0, 0);
        hits = 0; at = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 8'h00, 0, 0);
            if (o_timeout) begin hits++; at = k; end
        end
`ifdef RX_FIFO_TIMEOUT_EN
        chk("tmo hits", hits, 1);
        chk("tmo cycle", at, TMO);
`else
        chk("tmo hits off", hits, 0);
`endif

        // Timeout restarted by a second push after 10 idle cycles
        do_reset();
        cyc(1, 8'h5B, 0, 0);
        hits = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 8'h00, 0, 0);
            if (o_timeout) hits++;
        end
        chk("tmo early", hits, 0);
        cyc(1, 8'h5C, 0, 0);
        hits = 0; at = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 8'h00, 0, 0);
            if (o_timeout) begin hits++; at = k; end
        end
`ifdef RX_FIFO_TIMEOUT_EN
        chk("tmo2 hits", hits, 1);
        chk("tmo2 cycle", at, TMO);
`else
        chk("tmo2 hits off", hits, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
